// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the ID-stage hazard unit: reservation FSM encodings and
// the forward-select code that means "take the operand from the register file".
// Imported by the top; the match sub-module is purely parameter-driven.
package id_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RES_IDLE   = 2'd0,
    RES_ARMING = 2'd1,
    RES_ARMED  = 2'd2
  } res_state_t;

  localparam int FWD_RF = 0;

endpackage

// File: rtl/hz_match_prio.sv
// Priority search of the in-flight destination table for one source operand.
// Purely combinational; returns the youngest (lowest index) matching writer.
// Register 0 never matches.
module hz_match_prio #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int K_W        = 2
) (
  input  logic [REG_AW-1:0]            addr,
  input  logic [FWD_STAGES-1:0]        vld,
  input  logic [FWD_STAGES-1:0]        we,
  input  logic [FWD_STAGES-1:0]        ld,
  input  logic [FWD_STAGES*REG_AW-1:0] wa,
  output logic                         hit,
  output logic [K_W-1:0]               k,
  output logic                         ld_hit
);

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit    = 1'b0;
    k      = '0;
    ld_hit = 1'b0;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (vld[i] && we[i] && (addr != '0) && (wa[i*REG_AW +: REG_AW] == addr)) begin
        hit    = 1'b1;
        k      = K_W'(i);
        ld_hit = ld[i];
      end
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard unit: in-flight destination scoreboard driving operand
// forward selects and the load-use stall, plus the LL/SC reservation FSM.
// All outputs are combinational from inputs and current state.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_RDY   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic [REG_AW-1:0]                  id_rs_addr,
  input  logic [REG_AW-1:0]                  id_rt_addr,
  input  logic                               id_reads_rs,
  input  logic                               id_reads_rt,
  input  logic                               id_reg_we,
  input  logic [REG_AW-1:0]                  id_wr_addr,
  input  logic                               id_is_load,
  input  logic                               id_is_ll,
  input  logic                               id_is_sc,
  input  logic                               ex_is_store,
  input  logic [DATA_W-1:0]                  ex_mem_addr,
  input  logic                               res_clear,
  output logic [$clog2(FWD_STAGES+1)-1:0]    fwd_rs_sel,
  output logic [$clog2(FWD_STAGES+1)-1:0]    fwd_rt_sel,
  output logic                               stall,
  output logic                               atomic_id,
  output logic                               mem_sc_mask_id
);

  localparam int SEL_W = $clog2(FWD_STAGES + 1);
  localparam logic [SEL_W-1:0] LOAD_RDY_K = SEL_W'(LOAD_RDY);

  // Scoreboard, one bit-plane per field; index 0 is the instruction in EX.
  logic [FWD_STAGES-1:0]        sb_vld;
  logic [FWD_STAGES-1:0]        sb_we;
  logic [FWD_STAGES-1:0]        sb_ld;
  logic [FWD_STAGES-1:0]        sb_ll;
  logic [FWD_STAGES*REG_AW-1:0] sb_wa;

  logic             rs_hit, rt_hit;
  logic             rs_ld, rt_ld;
  logic [SEL_W-1:0] rs_k, rt_k;
  logic             rs_ld_wait, rt_ld_wait;
  logic             issue;

  res_state_t          state, state_nxt;
  logic [DATA_W-3:0]   res_addr, res_addr_nxt;
  logic [DATA_W-3:0]   ex_word;
  logic                ll_issue, sc_issue, ll_in_ex, store_hit;
  logic                addr_lo_unused;

  hz_match_prio #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .K_W(SEL_W)) u_match_rs (
    .addr   (id_rs_addr),
    .vld    (sb_vld),
    .we     (sb_we),
    .ld     (sb_ld),
    .wa     (sb_wa),
    .hit    (rs_hit),
    .k      (rs_k),
    .ld_hit (rs_ld)
  );

  hz_match_prio #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .K_W(SEL_W)) u_match_rt (
    .addr   (id_rt_addr),
    .vld    (sb_vld),
    .we     (sb_we),
    .ld     (sb_ld),
    .wa     (sb_wa),
    .hit    (rt_hit),
    .k      (rt_k),
    .ld_hit (rt_ld)
  );

  // A load that has not yet reached its forwardable stage blocks the reader.
  assign rs_ld_wait = rs_hit & rs_ld & (rs_k < LOAD_RDY_K);
  assign rt_ld_wait = rt_hit & rt_ld & (rt_k < LOAD_RDY_K);

  assign stall = id_valid & ((id_reads_rs & rs_ld_wait) | (id_reads_rt & rt_ld_wait));
  assign issue = id_valid & ~stall;

  // Select is the stage index + 1 when the producer's data is usable, else regfile.
  assign fwd_rs_sel = (rs_hit & ~rs_ld_wait) ? (rs_k + SEL_W'(1)) : SEL_W'(FWD_RF);
  assign fwd_rt_sel = (rt_hit & ~rt_ld_wait) ? (rt_k + SEL_W'(1)) : SEL_W'(FWD_RF);

  // Advance the scoreboard every cycle; a stalled ID slot enters as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_vld <= '0;
      sb_we  <= '0;
      sb_ld  <= '0;
      sb_ll  <= '0;
      sb_wa  <= '0;
    end else begin
      for (int i = FWD_STAGES - 1; i > 0; i--) begin
        sb_vld[i]                    <= sb_vld[i-1];
        sb_we[i]                     <= sb_we[i-1];
        sb_ld[i]                     <= sb_ld[i-1];
        sb_ll[i]                     <= sb_ll[i-1];
        sb_wa[i*REG_AW +: REG_AW]    <= sb_wa[(i-1)*REG_AW +: REG_AW];
      end
      sb_vld[0]          <= issue;
      sb_we[0]           <= issue & id_reg_we;
      sb_ld[0]           <= issue & id_is_load;
      sb_ll[0]           <= issue & id_is_ll;
      sb_wa[0 +: REG_AW] <= issue ? id_wr_addr : '0;
    end
  end

  // Reservation tracking compares word addresses; byte offset is irrelevant.
  assign ex_word        = ex_mem_addr[DATA_W-1:2];
  assign addr_lo_unused = ^ex_mem_addr[1:0];

  assign ll_issue  = id_is_ll & issue;
  assign sc_issue  = id_is_sc & issue;
  assign ll_in_ex  = sb_vld[0] & sb_ll[0];
  assign store_hit = (state == RES_ARMED) & ex_is_store & (ex_word == res_addr);

  assign atomic_id      = (state != RES_IDLE) & ~res_clear;
  assign mem_sc_mask_id = id_is_sc & ~(atomic_id & ~store_hit);

  // Reservation state and captured word address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RES_IDLE;
      res_addr <= '0;
    end else begin
      state    <= state_nxt;
      res_addr <= res_addr_nxt;
    end
  end

  // Next-state: clear wins, then a fresh LL restarts arming, then normal flow.
  always_comb begin
    state_nxt    = state;
    res_addr_nxt = res_addr;
    if (res_clear) begin
      state_nxt = RES_IDLE;
    end else if (ll_issue) begin
      state_nxt = RES_ARMING;
    end else begin
      case (state)
        RES_ARMING: begin
          if (ll_in_ex) begin
            state_nxt    = RES_ARMED;
            res_addr_nxt = ex_word;
          end
        end
        RES_ARMED: begin
          if (store_hit || sc_issue) state_nxt = RES_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
